spi_master: RTL and testbench

SPI_MASTER -- requirements
Module: spi_master

---
 rtl/spi_pkg.sv | 21 ++
 rtl/spi_clk_divider.sv | 40 ++++
 rtl/spi_master.sv | 154 +++++++++++++++
 tb/tb_spi_master.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_pkg
// Description : Shared definitions for the SPI master: the byte width used
//               to size transactions and the master state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

    localparam int BYTE_SIZE = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        HIGH  = 3'd2,
        LOW   = 3'd3,
        GAP   = 3'd4
    } spiState_t;

endpackage
`default_nettype wire

// File: rtl/spi_clk_divider.sv
`default_nettype none
// ============================================================================
// Module      : spi_clk_divider
// Description : Phase counter for the SPI master. Counts CLK_DIV system
//               cycles per phase and raises tickOut on the last one.
//               clearIn restarts the count so every new phase starts at 0.
// Ports       : clkIn    - system clock
//               nResetIn - asynchronous active-low reset
//               clearIn  - restart the phase count (state change / idle)
//               tickOut  - high during the last cycle of a phase
// Revision    : 1.0 - initial release
// ============================================================================
module spi_clk_divider #(
    parameter int CLK_DIV = 4
) (
    input  logic clkIn,
    input  logic nResetIn,
    input  logic clearIn,
    output logic tickOut
);

    localparam int c_CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(CLK_DIV - 1);

    logic [c_CNT_W-1:0] r_count;

    always_ff @(posedge clkIn or negedge nResetIn) begin
        if (!nResetIn) begin
            r_count <= '0;
        end else if (clearIn || tickOut) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + c_CNT_W'(1);
        end
    end

    assign tickOut = (r_count == c_LAST);

endmodule
`default_nettype wire

// File: rtl/spi_master.sv
`default_nettype none
// ============================================================================
// Module      : spi_master
// Description : SPI mode-0 master. Shifts an N = 8*PACKET_SIZE bit word out
//               MSB first on mosiOut while shifting misoIn in, with each SCK
//               half-period lasting CLK_DIV system cycles.
//               Optional feature macro: SPI_MASTER_BURST_EN - when defined,
//               startIn high on the final LOW cycle chains the next word
//               without releasing slave select.
// Ports       : clkIn, nResetIn (async, active low)
//               startIn, dataIn[N-1:0]   - transaction request / tx word
//               misoIn                   - serial data from the slave
//               ssOut, sckOut, mosiOut   - SPI bus outputs
//               dataOut[N-1:0]           - last received word
//               doneOut                  - one-cycle word-complete pulse
//               busyOut                  - high whenever not idle
// Revision    : 1.0 - initial release
// ============================================================================
module spi_master
    import spi_pkg::*;
#(
    parameter int PACKET_SIZE = 2,
    parameter int CLK_DIV     = 4
) (
    input  logic                              clkIn,
    input  logic                              nResetIn,
    input  logic                              startIn,
    input  logic [BYTE_SIZE*PACKET_SIZE-1:0]  dataIn,
    input  logic                              misoIn,
    output logic                              ssOut,
    output logic                              sckOut,
    output logic                              mosiOut,
    output logic [BYTE_SIZE*PACKET_SIZE-1:0]  dataOut,
    output logic                              doneOut,
    output logic                              busyOut
);

    localparam int c_N     = BYTE_SIZE * PACKET_SIZE;
    localparam int c_BIT_W = $clog2(c_N);
    localparam logic [c_BIT_W-1:0] c_LAST_BIT = c_BIT_W'(c_N - 1);

    spiState_t          r_state;
    spiState_t          w_nextState;
    logic [c_N-1:0]     r_txShift;
    logic [c_N-1:0]     r_rxShift;
    logic [c_N-1:0]     r_dataOut;
    logic [c_BIT_W-1:0] r_bitCnt;
    logic               r_ss;
    logic               r_sck;
    logic               r_done;
    logic               r_busy;
    logic               w_tick;
    logic               w_clear;
    logic               w_lastBit;
    logic               w_finish;

    // The counter restarts on every state change and is held at zero while
    // idle, so each phase is exactly CLK_DIV cycles long.
    assign w_clear = (w_nextState != r_state) || (r_state == IDLE);

    spi_clk_divider #(
        .CLK_DIV (CLK_DIV)
    ) u_clkDivider (
        .clkIn    (clkIn),
        .nResetIn (nResetIn),
        .clearIn  (w_clear),
        .tickOut  (w_tick)
    );

    assign w_lastBit = (r_bitCnt == c_LAST_BIT);

    always_comb begin
        w_nextState = r_state;
        w_finish    = 1'b0;
        case (r_state)
            IDLE:  if (startIn) w_nextState = SETUP;
            SETUP: if (w_tick)  w_nextState = HIGH;
            HIGH:  if (w_tick)  w_nextState = LOW;
            LOW: begin
                if (w_tick) begin
                    if (w_lastBit) begin
                        w_finish = 1'b1;
`ifdef SPI_MASTER_BURST_EN
                        w_nextState = startIn ? HIGH : GAP;
`else
                        w_nextState = GAP;
`endif
                    end else begin
                        w_nextState = HIGH;
                    end
                end
            end
            GAP:     if (w_tick) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clkIn or negedge nResetIn) begin
        if (!nResetIn) begin
            r_state   <= IDLE;
            r_txShift <= '0;
            r_rxShift <= '0;
            r_dataOut <= '0;
            r_bitCnt  <= '0;
            r_ss      <= 1'b1;
            r_sck     <= 1'b0;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_done  <= w_finish;
            // Bus outputs are registered from the next state so they change
            // on the same edge as the state itself.
            r_sck   <= (w_nextState == HIGH);
            r_ss    <= (w_nextState == IDLE) || (w_nextState == GAP);
            r_busy  <= (w_nextState != IDLE);

            if ((r_state == IDLE) && startIn) begin
                r_txShift <= dataIn;
                r_bitCnt  <= '0;
            end

            // Sample on the last HIGH cycle: the slave has had the full
            // half-period to settle its output after the previous fall.
            if ((r_state == HIGH) && w_tick) begin
                r_rxShift <= {r_rxShift[c_N-2:0], misoIn};
            end

            if ((r_state == LOW) && w_tick) begin
                if (!w_lastBit) begin
                    r_txShift <= {r_txShift[c_N-2:0], 1'b0};
                    r_bitCnt  <= r_bitCnt + c_BIT_W'(1);
                end else begin
                    r_dataOut <= r_rxShift;
`ifdef SPI_MASTER_BURST_EN
                    if (startIn) begin
                        r_txShift <= dataIn;
                        r_bitCnt  <= '0;
                    end
`endif
                end
            end
        end
    end

    assign ssOut   = r_ss;
    assign sckOut  = r_sck;
    assign mosiOut = r_txShift[c_N-1];
    assign dataOut = r_dataOut;
    assign doneOut = r_done;
    assign busyOut = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_spi_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_master
// Description : Self-checking bench for spi_master (PACKET_SIZE=2). Main
//               instance runs at CLK_DIV=2 with a selectable MISO source
//               (loopback, behavioural mode-0 slave, constant one); a second
//               instance at CLK_DIV=3 with MISO tied high.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_master;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] din   = 16'h0;
    logic        miso;
    logic        ss, sck, mosi, done, busy;
    logic [15:0] dout;

    logic        start3 = 1'b0;
    logic [15:0] din3   = 16'h0;
    logic        ss3, sck3, mosi3, done3, busy3;
    logic [15:0] dout3;

    always #5 clk = ~clk;

    spi_master #(.PACKET_SIZE(2), .CLK_DIV(2)) dut (
        .clkIn(clk), .nResetIn(rst_n), .startIn(start), .dataIn(din),
        .misoIn(miso), .ssOut(ss), .sckOut(sck), .mosiOut(mosi),
        .dataOut(dout), .doneOut(done), .busyOut(busy)
    );

    spi_master #(.PACKET_SIZE(2), .CLK_DIV(3)) dut3 (
        .clkIn(clk), .nResetIn(rst_n), .startIn(start3), .dataIn(din3),
        .misoIn(1'b1), .ssOut(ss3), .sckOut(sck3), .mosiOut(mosi3),
        .dataOut(dout3), .doneOut(done3), .busyOut(busy3)
    );

    // ---------------- MISO source and behavioural mode-0 slave ------------
    logic [1:0]  misoMode  = 2'd0;   // 0 loopback, 1 slave, 2 constant one
    logic [15:0] slaveLoad = 16'h0;
    logic [15:0] slaveTx   = 16'h0;
    logic [15:0] slaveRx   = 16'h0;
    logic        slvPrevSs  = 1'b1;
    logic        slvPrevSck = 1'b0;

    assign miso = (misoMode == 2'd0) ? mosi :
                  (misoMode == 2'd1) ? slaveTx[15] : 1'b1;

    always @(negedge clk) begin
        slvPrevSs  <= ss;
        slvPrevSck <= sck;
        if (slvPrevSs && !ss)        slaveTx <= slaveLoad;
        else if (slvPrevSck && !sck) slaveTx <= {slaveTx[14:0], 1'b0};
        if (!slvPrevSck && sck && !ss) slaveRx <= {slaveRx[14:0], mosi};
    end

    // ---------------- monitors ---------------------------------------------
    int          cyc = 0, doneCnt = 0, ssLowCnt = 0, riseCnt = 0;
    logic        prevSck = 1'b0;
    logic [15:0] gotQ[$];
    logic [15:0] expQ[$];
    int          doneCyc[$];

    always @(negedge clk) begin
        cyc     <= cyc + 1;
        prevSck <= sck;
        if (!ss)            ssLowCnt <= ssLowCnt + 1;
        if (sck && !prevSck) riseCnt <= riseCnt + 1;
        if (done) begin
            doneCnt <= doneCnt + 1;
            gotQ.push_back(dout);
            doneCyc.push_back(cyc);
        end
    end

    int   run3 = 0, minHalf3 = 1000, maxHalf3 = 0, done3Cnt = 0;
    logic prev3 = 1'b0;

    always @(negedge clk) begin
        if (done3) done3Cnt <= done3Cnt + 1;
        if (ss3) begin
            run3  <= 0;
            prev3 <= sck3;
        end else if (sck3 != prev3) begin
            if (run3 < minHalf3) minHalf3 <= run3;
            if (run3 > maxHalf3) maxHalf3 <= run3;
            run3  <= 1;
            prev3 <= sck3;
        end else begin
            run3 <= run3 + 1;
        end
    end

    // ---------------- checking helpers ------------------------------------
    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic waitIdle(input string name, input int budget);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin tick(); n++; end
        check(name, {31'd0, busy}, 32'd0);
    endtask

    task automatic waitDones(input string name, input int target, input int budget);
        int n = 0;
        while (doneCnt < target && n < budget) begin tick(); n++; end
        check(name, (doneCnt >= target) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic waitRises(input string name, input int target, input int budget);
        int n = 0;
        while (riseCnt < target && n < budget) begin tick(); n++; end
        check(name, (riseCnt >= target) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic sbDrain();
        while (gotQ.size() > 0 && expQ.size() > 0) begin
            logic [15:0] g, e;
            g = gotQ.pop_front();
            e = expQ.pop_front();
            check("sb_dout", {16'd0, g}, {16'd0, e});
        end
    endtask

    task automatic pulseStart(input logic [15:0] word);
        @(posedge clk); #1;
        din   = word;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        din   = ~word;   // only the value at acceptance may matter
    endtask

    typedef struct {
        logic [15:0] din;
        logic [1:0]  mode;
        logic [15:0] slv;
        logic [15:0] expd;
    } vec_t;

    task automatic runVec(input vec_t v);
        int d0, s0, r0;
        d0 = doneCnt; s0 = ssLowCnt; r0 = riseCnt;
        misoMode  = v.mode;
        slaveLoad = v.slv;
        expQ.push_back(v.expd);
        pulseStart(v.din);
        tick();
        check("accept_ss",   {31'd0, ss},   32'd0);
        check("accept_busy", {31'd0, busy}, 32'd1);
        check("accept_mosi", {31'd0, mosi}, {31'd0, v.din[15]});
        waitIdle("vec_timeout", 300);
        check("vec_done_cnt", doneCnt - d0, 32'd1);
        check("vec_ss_low",   ssLowCnt - s0, 32'd66);
        check("vec_sck_rises", riseCnt - r0, 32'd16);
        if (v.mode == 2'd1) check("slave_rx", {16'd0, slaveRx}, {16'd0, v.din});
        sbDrain();
    endtask

    vec_t vecs[6];

    initial begin
        int d0, s0, r0;

        vecs[0] = '{din: 16'hA55A, mode: 2'd0, slv: 16'h0000, expd: 16'hA55A};
        vecs[1] = '{din: 16'hBEEF, mode: 2'd1, slv: 16'h1234, expd: 16'h1234};
        vecs[2] = '{din: 16'h0000, mode: 2'd0, slv: 16'h0000, expd: 16'h0000};
        vecs[3] = '{din: 16'hFFFF, mode: 2'd0, slv: 16'h0000, expd: 16'hFFFF};
        vecs[4] = '{din: 16'h8001, mode: 2'd1, slv: 16'h7FFE, expd: 16'h7FFE};
        vecs[5] = '{din: 16'h0001, mode: 2'd2, slv: 16'h0000, expd: 16'hFFFF};

        // Reset state
        repeat (3) tick();
        check("rst_ss",   {31'd0, ss},   32'd1);
        check("rst_sck",  {31'd0, sck},  32'd0);
        check("rst_mosi", {31'd0, mosi}, 32'd0);
        check("rst_dout", {16'd0, dout}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) tick();

        for (int i = 0; i < 6; i++) runVec(vecs[i]);

        // Start pulse during bit 5 is ignored
        misoMode = 2'd0;
        d0 = doneCnt; r0 = riseCnt;
        expQ.push_back(16'h1234);
        pulseStart(16'h1234);
        waitRises("mid_start_wait", r0 + 5, 200);
        din   = 16'hFFFF;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        waitIdle("mid_start_timeout", 300);
        repeat (10) tick();
        check("mid_start_done_cnt", doneCnt - d0, 32'd1);
        check("mid_start_idle", {31'd0, busy}, 32'd0);
        sbDrain();

        // Reset asserted during bit 7 aborts without a done pulse
        d0 = doneCnt; r0 = riseCnt;
        pulseStart(16'h3C3C);
        waitRises("abort_wait", r0 + 7, 200);
        check("abort_sck_before", {31'd0, sck}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_ss",   {31'd0, ss},   32'd1);
        check("abort_sck",  {31'd0, sck},  32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_dout", {16'd0, dout}, 32'd0);
        repeat (3) tick();
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) tick();
        check("abort_no_done", doneCnt - d0, 32'd0);
        runVec('{din: 16'h5A5A, mode: 2'd0, slv: 16'h0000, expd: 16'h5A5A});

`ifdef SPI_MASTER_BURST_EN
        // Burst: two words with slave select held low throughout
        d0 = doneCnt; s0 = ssLowCnt; r0 = riseCnt;
        misoMode = 2'd0;
        expQ.push_back(16'h0001);
        expQ.push_back(16'h8000);
        @(posedge clk); #1;
        din   = 16'h0001;
        start = 1'b1;
        @(posedge clk); #1;
        din   = 16'h8000;
        waitDones("burst_first", d0 + 1, 200);
        start = 1'b0;
        waitIdle("burst_timeout", 300);
        check("burst_done_cnt", doneCnt - d0, 32'd2);
        check("burst_rises",    riseCnt - r0, 32'd32);
        check("burst_ss_low",   ssLowCnt - s0, 32'd130);
        if (doneCyc.size() >= 2)
            check("burst_spacing", doneCyc[doneCyc.size()-1] - doneCyc[doneCyc.size()-2], 32'd64);
        sbDrain();
`else
        // Held start: back-to-back transactions, slave select released between
        d0 = doneCnt;
        misoMode = 2'd0;
        expQ.push_back(16'h0F0F);
        expQ.push_back(16'h0F0F);
        @(posedge clk); #1;
        din   = 16'h0F0F;
        start = 1'b1;
        waitDones("b2b_first", d0 + 1, 200);
        check("b2b_ss_released", {31'd0, ss}, 32'd1);
        begin
            int n = 0;
            while (ss !== 1'b0 && n < 50) begin tick(); n++; end
        end
        check("b2b_second_start", {31'd0, ss}, 32'd0);
        start = 1'b0;
        waitIdle("b2b_timeout", 300);
        check("b2b_done_cnt", doneCnt - d0, 32'd2);
        sbDrain();
`endif

        // CLK_DIV=3 instance with MISO tied high
        @(posedge clk); #1;
        din3   = 16'h0000;
        start3 = 1'b1;
        @(posedge clk); #1;
        start3 = 1'b0;
        begin
            int n = 0;
            while (done3Cnt < 1 && n < 400) begin tick(); n++; end
        end
        repeat (5) tick();
        check("div3_done_cnt", done3Cnt, 32'd1);
        check("div3_dout",     {16'd0, dout3}, 32'h0000FFFF);
        check("div3_half_min", minHalf3, 32'd3);
        check("div3_half_max", maxHalf3, 32'd3);

        check("sb_leftover", gotQ.size() + expQ.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
